// File: rtl/gpu_pixel_arbiter.sv
// Burst-locked round-robin arbiter sharing the framebuffer pixel port between the line and
// fill engines. Define GPU_PIXEL_ARB_STATS_EN to add saturating pixel/stall counters.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 10
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_pixel_arbiter #(
   parameter int MAX_BURST = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     line_valid_i,
   input  logic [`WIDTH_BITS-1:0]   line_x_i,
   input  logic [`HEIGHT_BITS-1:0]  line_y_i,
   input  logic [`CHANNEL_BITS-1:0] line_r_i,
   input  logic [`CHANNEL_BITS-1:0] line_g_i,
   input  logic [`CHANNEL_BITS-1:0] line_b_i,
   output logic                     line_ready_o,
   input  logic                     fill_valid_i,
   input  logic [`WIDTH_BITS-1:0]   fill_x_i,
   input  logic [`HEIGHT_BITS-1:0]  fill_y_i,
   input  logic [`CHANNEL_BITS-1:0] fill_r_i,
   input  logic [`CHANNEL_BITS-1:0] fill_g_i,
   input  logic [`CHANNEL_BITS-1:0] fill_b_i,
   output logic                     fill_ready_o,
   output logic                     pix_valid_o,
   output logic [`WIDTH_BITS-1:0]   pix_x_o,
   output logic [`HEIGHT_BITS-1:0]  pix_y_o,
   output logic [`CHANNEL_BITS-1:0] pix_r_o,
   output logic [`CHANNEL_BITS-1:0] pix_g_o,
   output logic [`CHANNEL_BITS-1:0] pix_b_o,
   input  logic                     pix_ready_i,
   output logic                     busy_o
`ifdef GPU_PIXEL_ARB_STATS_EN
   ,
   output logic [15:0]              line_pix_cnt_o,
   output logic [15:0]              fill_pix_cnt_o,
   output logic [15:0]              stall_cnt_o
`endif
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] GNT_LINE = 2'd1;
   localparam logic [1:0] GNT_FILL = 2'd2;
   localparam logic       SRC_LINE = 1'b0;
   localparam logic       SRC_FILL = 1'b1;
   localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

   logic [1:0] state, state_n, other_gnt;
   logic [7:0] burst_cnt;
   logic       last_src, gap;
   logic       out_free, line_xfer, fill_xfer, xfer;
   logic       own_valid, other_valid, burst_done, switching;

   // gap blanks the readies for one cycle after a burst-limit handover
   assign out_free     = !pix_valid_o || pix_ready_i;
   assign line_ready_o = (state == GNT_LINE) && !gap && out_free;
   assign fill_ready_o = (state == GNT_FILL) && !gap && out_free;
   assign line_xfer    = line_valid_i && line_ready_o;
   assign fill_xfer    = fill_valid_i && fill_ready_o;
   assign xfer         = line_xfer || fill_xfer;

   assign own_valid   = (state == GNT_LINE) ? line_valid_i : fill_valid_i;
   assign other_valid = (state == GNT_LINE) ? fill_valid_i : line_valid_i;
   assign other_gnt   = (state == GNT_LINE) ? GNT_FILL : GNT_LINE;
   assign burst_done  = xfer && ((burst_cnt + 8'd1) == BURST_MAX);
   assign switching   = (state_n != state);

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (line_valid_i && (!fill_valid_i || last_src == SRC_FILL)) state_n = GNT_LINE;
            else if (fill_valid_i)                                        state_n = GNT_FILL;
         end
         GNT_LINE, GNT_FILL: begin
            if (!own_valid)                     state_n = other_valid ? other_gnt : IDLE;
            else if (burst_done && other_valid) state_n = other_gnt;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         last_src  <= SRC_FILL;
         burst_cnt <= 8'd0;
         gap       <= 1'b0;
      end else begin
         state <= state_n;
         gap   <= xfer && switching;
         if (switching) begin
            burst_cnt <= 8'd0;
            if (state_n == GNT_LINE)      last_src <= SRC_LINE;
            else if (state_n == GNT_FILL) last_src <= SRC_FILL;
         end else if (burst_done) begin
            burst_cnt <= 8'd0;
         end else if (xfer) begin
            burst_cnt <= burst_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_valid_o <= 1'b0;
         pix_x_o     <= '0;
         pix_y_o     <= '0;
         pix_r_o     <= '0;
         pix_g_o     <= '0;
         pix_b_o     <= '0;
      end else if (xfer) begin
         pix_valid_o <= 1'b1;
         pix_x_o     <= line_xfer ? line_x_i : fill_x_i;
         pix_y_o     <= line_xfer ? line_y_i : fill_y_i;
         pix_r_o     <= line_xfer ? line_r_i : fill_r_i;
         pix_g_o     <= line_xfer ? line_g_i : fill_g_i;
         pix_b_o     <= line_xfer ? line_b_i : fill_b_i;
      end else if (pix_ready_i) begin
         pix_valid_o <= 1'b0;
      end
   end

   assign busy_o = (state != IDLE) || pix_valid_o;

`ifdef GPU_PIXEL_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_pix_cnt_o <= 16'd0;
         fill_pix_cnt_o <= 16'd0;
         stall_cnt_o    <= 16'd0;
      end else begin
         if (line_xfer && line_pix_cnt_o != 16'hFFFF) line_pix_cnt_o <= line_pix_cnt_o + 16'd1;
         if (fill_xfer && fill_pix_cnt_o != 16'hFFFF) fill_pix_cnt_o <= fill_pix_cnt_o + 16'd1;
         if (pix_valid_o && !pix_ready_i && stall_cnt_o != 16'hFFFF)
            stall_cnt_o <= stall_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gpu_pixel_arbiter.sv
// Bench for gpu_pixel_arbiter: directed arbitration sequences plus randomized traffic checked
// against a one-deep acceptance-order scoreboard and burst-fairness limits.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 10
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module tb_gpu_pixel_arbiter;
  localparam int MB = 4;
  localparam int WB = `WIDTH_BITS;
  localparam int HB = `HEIGHT_BITS;
  localparam int CB = `CHANNEL_BITS;
  localparam int PW = WB + HB + 3*CB;
  typedef logic [PW-1:0] pix_t;  // {x, y, r, g, b}

  logic clk = 1'b0, rst = 1'b1;
  logic lv = 1'b0, fv = 1'b0, prdy = 1'b1;
  pix_t lp = '0, fp = '0, op;
  logic line_ready_o, fill_ready_o, pix_valid_o, busy_o;
  logic [WB-1:0] px;
  logic [HB-1:0] py;
  logic [CB-1:0] pr_c, pg_c, pb_c;
`ifdef GPU_PIXEL_ARB_STATS_EN
  logic [15:0] line_cnt, fill_cnt, stall_cnt;
`endif

  assign op = {px, py, pr_c, pg_c, pb_c};

  gpu_pixel_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .line_valid_i(lv), .line_x_i(lp[PW-1 -: WB]), .line_y_i(lp[3*CB+HB-1 -: HB]),
    .line_r_i(lp[3*CB-1 -: CB]), .line_g_i(lp[2*CB-1 -: CB]), .line_b_i(lp[CB-1:0]),
    .line_ready_o(line_ready_o),
    .fill_valid_i(fv), .fill_x_i(fp[PW-1 -: WB]), .fill_y_i(fp[3*CB+HB-1 -: HB]),
    .fill_r_i(fp[3*CB-1 -: CB]), .fill_g_i(fp[2*CB-1 -: CB]), .fill_b_i(fp[CB-1:0]),
    .fill_ready_o(fill_ready_o),
    .pix_valid_o(pix_valid_o), .pix_x_o(px), .pix_y_o(py),
    .pix_r_o(pr_c), .pix_g_o(pg_c), .pix_b_o(pb_c),
    .pix_ready_i(prdy), .busy_o(busy_o)
`ifdef GPU_PIXEL_ARB_STATS_EN
    , .line_pix_cnt_o(line_cnt), .fill_pix_cnt_o(fill_cnt), .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  pix_t acc_q[$];
  int lrun = 0, frun = 0, last_x = 0;
  int n_line = 0, n_fill = 0, n_stall = 0;
  logic la_s, fa_s, lr_s, fr_s, pv_s;
  pix_t op_s, held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pix_t newpix();
    return pix_t'({$urandom(), $urandom()});
  endfunction

  // Model: accepted pixels leave in acceptance order through a single output slot.
  task automatic sample();
    la_s = lv & line_ready_o;
    fa_s = fv & fill_ready_o;
    lr_s = line_ready_o; fr_s = fill_ready_o; pv_s = pix_valid_o; op_s = op;
    chk("one_ready", 64'(line_ready_o & fill_ready_o), 64'(0));
    chk("out_valid", 64'(pix_valid_o), 64'(acc_q.size() != 0));
    if (acc_q.size() != 0) chk("out_data", 64'(op), 64'(acc_q[0]));
    if (pix_valid_o && !prdy) begin
      chk("stall_ready", 64'(line_ready_o | fill_ready_o), 64'(0));
      n_stall++;
    end
    if (pix_valid_o && prdy && acc_q.size() != 0) void'(acc_q.pop_front());
    if (!fv || fa_s) lrun = 0; else if (la_s) lrun++;
    if (!lv || la_s) frun = 0; else if (fa_s) frun++;
    chk("burst_len", 64'(lrun <= MB && frun <= MB), 64'(1));
    if (la_s) begin acc_q.push_back(lp); n_line++; end
    if (fa_s) begin acc_q.push_back(fp); n_fill++; end
    last_x = la_s ? 1 : (fa_s ? 2 : 0);
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic refresh();
    if (la_s) lp = newpix();
    if (fa_s) fp = newpix();
  endtask

  task automatic do_reset();
    lv = 1'b0; fv = 1'b0; prdy = 1'b1;
    rst = 1'b1;
    #1;
    acc_q.delete();
    lrun = 0; frun = 0; n_line = 0; n_fill = 0; n_stall = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int t4_l[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
  int t4_f[8] = '{1, 1, 1, 1, 1, 0, 1, 1};
  int t4_e[8] = '{0, 1, 1, 0, 2, 0, 0, 1};

  initial begin
    lp = newpix(); fp = newpix();
    #2;
    chk("rst_valid", 64'(pix_valid_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_ready", 64'({line_ready_o, fill_ready_o}), 64'(0));
    chk("rst_data", 64'(op), 64'(0));
    do_reset();

    // line alone: one idle cycle, then a pixel every cycle
    lv = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t1_xfer", 64'(last_x), 64'(k == 0 ? 0 : 1));
      chk("t1_fill_ready", 64'(fr_s), 64'(0));
      refresh();
    end

    // both valid: 4 line, dead, 4 fill, dead, ...
    do_reset();
    lv = 1'b1; fv = 1'b1;
    for (int k = 0; k < 22; k++) begin
      int j, e;
      step();
      j = (k - 1) % 10;
      e = (k == 0) ? 0 : (j < 4) ? 1 : (j == 4) ? 0 : (j < 9) ? 2 : 0;
      chk("t2_order", 64'(last_x), 64'(e));
      refresh();
    end

    // fill stalled by the framebuffer for 5 cycles
    do_reset();
    fv = 1'b1;
    step();
    step();
    chk("t3_accept", 64'(last_x), 64'(2));
    held = fp;
    fp = newpix();
    prdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_hold_valid", 64'(pv_s), 64'(1));
      chk("t3_hold_data", 64'(op_s), 64'(held));
      chk("t3_fill_ready", 64'(fr_s), 64'(0));
    end
    prdy = 1'b1;
    for (int k = 0; k < 4; k++) begin step(); refresh(); end

    // line drops after 2 pixels, fill takes over, next tie returns to line
    do_reset();
    for (int k = 0; k < 8; k++) begin
      lv = t4_l[k][0]; fv = t4_f[k][0];
      step();
      chk("t4_seq", 64'(last_x), 64'(t4_e[k]));
      refresh();
    end

    // asynchronous reset while a pixel is held in the output register
    do_reset();
    lv = 1'b1; prdy = 1'b0;
    step();
    step();
    chk("t5_pre_valid", 64'(pix_valid_o), 64'(1));
    rst = 1'b1;
    #1;
    chk("t5_valid", 64'(pix_valid_o), 64'(0));
    chk("t5_busy", 64'(busy_o), 64'(0));
    chk("t5_ready", 64'(line_ready_o), 64'(0));
    chk("t5_data", 64'(op), 64'(0));
    lv = 1'b0;
    do_reset();

    // randomized traffic with valid drops and framebuffer backpressure
    lp = newpix(); fp = newpix();
    for (int k = 0; k < 3000; k++) begin
      step();
      refresh();
      if (la_s || !lv) lv = ($urandom_range(99) < 65); else lv = ($urandom_range(9) != 0);
      if (fa_s || !fv) fv = ($urandom_range(99) < 65); else fv = ($urandom_range(9) != 0);
      prdy = ($urandom_range(99) < 70);
    end
`ifdef GPU_PIXEL_ARB_STATS_EN
    chk("stat_line", 64'(line_cnt), 64'(n_line > 65535 ? 65535 : n_line));
    chk("stat_fill", 64'(fill_cnt), 64'(n_fill > 65535 ? 65535 : n_fill));
    chk("stat_stall", 64'(stall_cnt), 64'(n_stall > 65535 ? 65535 : n_stall));
`endif
    lv = 1'b0; fv = 1'b0; prdy = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("drain_busy", 64'(busy_o), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpu_pixel_arbiter.md
# gpu_pixel_arbiter

Shares the single framebuffer pixel-write port between the two pixel engines, gpu_draw_line and gpu_fill_rect. It sits between those engines and the framebuffer writer and replaces combinational output muxing with an arbitrated, registered handshake. Grants are burst-locked and round-robin, and pixels are never dropped under framebuffer backpressure.

## Interface
Parameters:
- MAX_BURST, default 8: maximum consecutive pixels accepted from one source while the other source is requesting; range 1..255.
- Coordinate and colour widths come from `` `WIDTH_BITS``, `` `HEIGHT_BITS`` and `` `CHANNEL_BITS`` in gpu_definitions.vh.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- line_valid_i, in, 1: line engine presents a pixel.
- line_x_i / line_y_i, in, `` `WIDTH_BITS`` / `` `HEIGHT_BITS``: line engine pixel coordinate.
- line_r_i / line_g_i / line_b_i, in, `` `CHANNEL_BITS`` each: line engine colour.
- line_ready_o, out, 1: line pixel accepted this cycle when high together with line_valid_i.
- fill_valid_i, fill_x_i, fill_y_i, fill_r_i, fill_g_i, fill_b_i, fill_ready_o: fill engine equivalents, same widths.
- pix_valid_o, out, 1: output pixel valid.
- pix_x_o / pix_y_o / pix_r_o / pix_g_o / pix_b_o, out: output pixel.
- pix_ready_i, in, 1: framebuffer writer accepts the output pixel.
- busy_o, out, 1: high when the state is not IDLE or pix_valid_o is high.

## Operation
- FSM states: IDLE, GNT_LINE, GNT_FILL. A last_src register holds the source most recently granted.
- **IDLE**
  - Only one source valid: go to that source's GNT state.
  - Both valid: grant the source that is not last_src.
  - Neither valid: stay in IDLE.
  - No ready is asserted while in IDLE.
- **GNT_s**
  - Only source s can be readied: s_ready_o = !pix_valid_o | pix_ready_i (combinational).
  - The other source's ready is 0.
- **Transfer:** a transfer occurs when s_valid_i & s_ready_o. On a transfer:
  - The output register loads s's pixel and pix_valid_o is set.
  - burst_cnt increments; it is 8 bits.
- **Output register:** if pix_ready_i is high and no new load occurs, pix_valid_o clears. While pix_valid_o & !pix_ready_i, the output holds stable.
- **Release from GNT_s** (evaluated each cycle, priority order):
  1. s_valid_i low: move to the other GNT state if the other source is valid, else IDLE.
  2. A transfer makes burst_cnt reach MAX_BURST and the other source is valid: move to the other GNT state.
  3. burst_cnt reaches MAX_BURST and the other source is idle: stay and clear burst_cnt.
- **On any state change:** burst_cnt clears and last_src updates to the newly granted source.
- **Ordering:** pixels from one source leave in acceptance order. Bursts never interleave mid-beat.

## Timing
- Reset values: state=IDLE, last_src=FILL (line wins the first tie), burst_cnt=0, pix_valid_o=0, all pix data outputs 0, both readies 0, busy_o=0.
- Arbitration latency: 1 cycle from the first valid in IDLE to grant. A source switch costs 1 dead cycle with no transfer.
- Data latency: a pixel accepted at edge N appears on pix_*_o after edge N. Throughput is 1 pixel/cycle while pix_ready_i stays high.
- Sustained pix_ready_i=0: pix_valid_o stays high with the output frozen, the granted ready stays 0, and no source loses data.
- Reset asserted mid-burst: all state clears immediately. The pixel pending in the output register is discarded. Engines are reset by the same rst.
- MAX_BURST=1 with both sources valid: grants strictly alternate, one pixel, then one dead cycle.

## Configuration
- GPU_PIXEL_ARB_STATS_EN defined adds three outputs:
  - line_pix_cnt_o, 16 bits: saturating count of accepted line pixels.
  - fill_pix_cnt_o, 16 bits: saturating count of accepted fill pixels.
  - stall_cnt_o, 16 bits: saturating count of cycles with pix_valid_o & !pix_ready_i.
  - All three reset to 0 and saturate at 0xFFFF.
- Undefined: these ports and their counters do not exist. The arbitration behaviour is identical either way.

## Test plan
- Reset, then line_valid_i=1 alone with pix_ready_i=1 → grant after 1 cycle, then 1 pixel/cycle; pix_x_o follows line_x_i with 1-cycle delay; fill_ready_o stays 0.
- Both sources valid continuously, MAX_BURST=4, pix_ready_i=1 → output order is 4 line pixels, dead cycle, 4 fill pixels, dead cycle, repeating.
- Fill granted, pix_ready_i held 0 for 5 cycles → pix_valid_o=1 with data frozen and fill_ready_o=0 throughout; after release, no pixel is lost or duplicated.
- Line drops valid after 2 pixels while fill is valid → switch to GNT_FILL with burst_cnt=0; last_src=FILL, so the next tie goes to line.
- rst pulsed mid-burst with pix_valid_o=1 → pix_valid_o=0, busy_o=0 and state IDLE immediately, without waiting for a clock edge.
- With GPU_PIXEL_ARB_STATS_EN: 10 line pixels, 6 fill pixels and 3 stall cycles → counters read 10, 6, 3. Pre-load near saturation → counters hold at 0xFFFF.
